serial_complementer_n: RTL and testbench

Parametrised serial two's complementer with a start/busy/done handshake. A WIDTH-bit operand is loaded into a shift register. One bit per clock, LSB first, is processed through a single "first one seen" flag flip-flop. The complemented word is then presented in parallel, and a serial bit stream is emitted alongside it. This block supersedes the fixed 4-bit complementer in the arithmetic datapath and adds arbitrary width, a handshake, an overflow indication and an optional ones'-complement mode.

---
 rtl/serial_complementer_n_if.sv | 23 ++
 rtl/serial_complementer_n.sv | 133 +++++++++++++
 tb/tb_serial_complementer_n.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/serial_complementer_n_if.sv
// rtl/serial_complementer_n_if.sv - start/busy/done handshake and result bundle for serial_complementer_n
// The mode member exists only when SERCOMP_ONES_MODE_EN is defined.
interface serial_complementer_n_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             ovf;
  logic             sout;
  logic             sout_valid;
`ifdef SERCOMP_ONES_MODE_EN
  logic             mode;

  modport master (output start, din, mode, input busy, done, dout, ovf, sout, sout_valid);
  modport slave  (input start, din, mode, output busy, done, dout, ovf, sout, sout_valid);
`else
  modport master (output start, din, input busy, done, dout, ovf, sout, sout_valid);
  modport slave  (input start, din, output busy, done, dout, ovf, sout, sout_valid);
`endif
endinterface

// File: rtl/serial_complementer_n.sv
// rtl/serial_complementer_n.sv - serial LSB-first two's complementer with start/busy/done handshake
// Optional ones'-complement mode is enabled by defining SERCOMP_ONES_MODE_EN.
module serial_complementer_n #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 set_n,
  serial_complementer_n_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             flag_q, flag_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;

  logic             ones_mode;
  logic             ones_load;
  logic             out_bit;
  logic             next_bit;
  logic             next_flag;

`ifdef SERCOMP_ONES_MODE_EN
  logic mode_q, mode_d;
  assign ones_mode = mode_q;
  assign ones_load = bus.mode;
`else
  assign ones_mode = 1'b0;
  assign ones_load = 1'b0;
`endif

  // sout is registered one bit ahead: bit k+1 is precomputed while bit k is processed
  assign out_bit   = ones_mode ? ~shreg_q[0] : (shreg_q[0] ^ flag_q);
  assign next_flag = flag_q | shreg_q[0];
  assign next_bit  = ones_mode ? ~shreg_q[1] : (shreg_q[1] ^ next_flag);

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    flag_d       = flag_q;
    count_d      = count_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    dout_d       = dout_q;
    ovf_d        = ovf_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
`ifdef SERCOMP_ONES_MODE_EN
    mode_d       = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d      = bus.din;
          flag_d       = 1'b0;
          count_d      = '0;
          busy_d       = 1'b1;
          sout_d       = ones_load ? ~bus.din[0] : bus.din[0];
          sout_valid_d = 1'b1;
`ifdef SERCOMP_ONES_MODE_EN
          mode_d       = bus.mode;
`endif
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = {out_bit, shreg_q[WIDTH-1:1]};
        flag_d  = next_flag;
        if (count_q == CW'(WIDTH - 1)) begin
          // Most-negative operand: MSB set with no lower one seen before it
          dout_d       = {out_bit, shreg_q[WIDTH-1:1]};
          ovf_d        = ~ones_mode & ~flag_q & shreg_q[0];
          done_d       = 1'b1;
          busy_d       = 1'b0;
          sout_d       = 1'b0;
          sout_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          count_d = count_q + CW'(1);
          sout_d  = next_bit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!set_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      flag_q       <= 1'b0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dout_q       <= '0;
      ovf_q        <= 1'b0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
`ifdef SERCOMP_ONES_MODE_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      flag_q       <= flag_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dout_q       <= dout_d;
      ovf_q        <= ovf_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
`ifdef SERCOMP_ONES_MODE_EN
      mode_q       <= mode_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.dout       = dout_q;
  assign bus.ovf        = ovf_q;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
endmodule

// File: tb/tb_serial_complementer_n.sv
// tb/tb_serial_complementer_n.sv - scoreboard bench for serial_complementer_n at WIDTH=4 and WIDTH=16
// Ones'-mode steps run only when SERCOMP_ONES_MODE_EN is defined.
module tb_serial_complementer_n;
  logic clk;
  logic set_n;

  serial_complementer_n_if #(.WIDTH(4))  if4 ();
  serial_complementer_n_if #(.WIDTH(16)) if16 ();

  serial_complementer_n #(.WIDTH(4))  dut4  (.clk(clk), .set_n(set_n), .bus(if4));
  serial_complementer_n #(.WIDTH(16)) dut16 (.clk(clk), .set_n(set_n), .bus(if16));

  typedef struct {
    logic [63:0] dout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [63:0] dout, input logic ovf);
    exp_t e;
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_dout"}, dout, e.dout);
      check({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
    end
  endtask

  task automatic do4(input string tag, input logic [3:0] d, input logic m);
    exp_t       e;
    logic [3:0] r;
    r      = m ? ~d : (4'd0 - d);
    e.dout = {60'd0, r};
    e.ovf  = !m && (d == 4'b1000);
    if4.start = 1'b1;
    if4.din   = d;
`ifdef SERCOMP_ONES_MODE_EN
    if4.mode  = m;
`endif
    sb.push_back(e);
    tick();
    if4.start = 1'b0;
    if4.din   = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check({tag, "_busy"}, 64'(if4.busy), 64'd1);
      check({tag, "_valid"}, 64'(if4.sout_valid), 64'd1);
      check({tag, "_sout"}, 64'(if4.sout), 64'(r[i]));
      check({tag, "_nodone"}, 64'(if4.done), 64'd0);
    end
    tick();
    check({tag, "_done"}, 64'(if4.done), 64'd1);
    check({tag, "_busy_end"}, 64'(if4.busy), 64'd0);
    check({tag, "_valid_end"}, 64'(if4.sout_valid), 64'd0);
    pop_check(tag, {60'd0, if4.dout}, if4.ovf);
  endtask

  task automatic do16(input string tag, input logic [15:0] d);
    exp_t        e;
    logic [15:0] r;
    r      = 16'd0 - d;
    e.dout = {48'd0, r};
    e.ovf  = (d == 16'h8000);
    if16.start = 1'b1;
    if16.din   = d;
`ifdef SERCOMP_ONES_MODE_EN
    if16.mode  = 1'b0;
`endif
    sb.push_back(e);
    tick();
    if16.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      if16.start = (i == 5);
      if16.din   = (i == 5) ? 16'h1234 : 16'($urandom);
      check({tag, "_sout"}, 64'(if16.sout), 64'(r[i]));
      check({tag, "_nodone"}, 64'(if16.done), 64'd0);
    end
    if16.start = 1'b0;
    tick();
    check({tag, "_done"}, 64'(if16.done), 64'd1);
    pop_check(tag, {48'd0, if16.dout}, if16.ovf);
    tick();
    check({tag, "_no_queued_busy"}, 64'(if16.busy), 64'd0);
    check({tag, "_no_queued_done"}, 64'(if16.done), 64'd0);
  endtask

  initial begin
    logic seen_done;
    set_n      = 1'b0;
    if4.start  = 1'b0;
    if4.din    = '0;
    if16.start = 1'b0;
    if16.din   = '0;
`ifdef SERCOMP_ONES_MODE_EN
    if4.mode   = 1'b0;
    if16.mode  = 1'b0;
`endif
    tick();
    tick();
    check("rst_busy", 64'(if4.busy), 64'd0);
    check("rst_done", 64'(if4.done), 64'd0);
    check("rst_dout", 64'(if4.dout), 64'd0);
    check("rst_ovf", 64'(if4.ovf), 64'd0);
    check("rst_sout", 64'(if4.sout), 64'd0);
    check("rst_valid", 64'(if4.sout_valid), 64'd0);
    check("rst_dout16", 64'(if16.dout), 64'd0);
    set_n = 1'b1;
    tick();

    do4("c0101", 4'b0101, 1'b0);
    tick();
    do4("c1100", 4'b1100, 1'b0);
    do4("b2b0110", 4'b0110, 1'b0);
    tick();
    do4("c1000", 4'b1000, 1'b0);
    do4("c0000", 4'b0000, 1'b0);
    tick();
    do16("w16_0001", 16'h0001);
    do16("w16_8000", 16'h8000);

    // Reset asserted during the second shift cycle aborts the conversion
    if4.start = 1'b1;
    if4.din   = 4'b0101;
    tick();
    if4.start = 1'b0;
    tick();
    set_n = 1'b0;
    tick();
    check("abort_busy", 64'(if4.busy), 64'd0);
    check("abort_done", 64'(if4.done), 64'd0);
    check("abort_dout", 64'(if4.dout), 64'd0);
    check("abort_ovf", 64'(if4.ovf), 64'd0);
    check("abort_sout", 64'(if4.sout), 64'd0);
    check("abort_valid", 64'(if4.sout_valid), 64'd0);
    set_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen_done = seen_done | if4.done | if4.busy;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    check("abort_dout_hold", 64'(if4.dout), 64'd0);
    do4("after_rst", 4'b0011, 1'b0);

`ifdef SERCOMP_ONES_MODE_EN
    tick();
    do4("ones0101", 4'b0101, 1'b1);
    do4("ones1000", 4'b1000, 1'b1);
    do4("twos_again", 4'b1000, 1'b0);
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
